// File: rtl/time_counters.sv
// ---------------------------------------------------------------------------
// time_counters
//
// BCD timekeeping register bank holding seconds, minutes and hours. In normal
// mode the fields advance as a clock on the 1 Hz tick, with carries rippling
// from seconds to minutes to hours. In set mode each enabled field steps by
// one on the set tick and wraps on its own, without carrying into the next
// field. The BCD outputs feed the display multiplexer.
//
// Parameters:
//   HOURS_MAX   last hour value before wrapping to 00 (decimal, 24-hour)
//   MINSEC_MAX  last minute/second value before wrapping to 00 (decimal)
//
// Ports:
//   i_Clock                      system clock, rising edge
//   i_Reset                      synchronous active-high reset, clears all
//   i_Tick_1Hz                   single-cycle timekeeping strobe
//   i_Tick_Set                   single-cycle set-mode step strobe
//   i_Counters_Reset             holds seconds at 00 while high
//   i_Counters_Enable_Increment  1 = set mode, 0 = normal timekeeping
//   i_Counters_Enable_Count      per-field enables {hours, minutes, seconds}
//   o_Seconds                    BCD seconds {tens, ones}
//   o_Minutes                    BCD minutes {tens, ones}
//   o_Hours                      BCD hours {tens, ones}
//   o_Day_Wrap                   one-cycle pulse on 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module time_counters #(
  parameter int HOURS_MAX  = 23,
  parameter int MINSEC_MAX = 59
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tick_1Hz,
  input  logic       i_Tick_Set,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [7:0] o_Seconds,
  output logic [7:0] o_Minutes,
  output logic [7:0] o_Hours,
  output logic       o_Day_Wrap
);

  // Wrap limits in BCD form so they compare directly against the registers.
  localparam logic [7:0] HOURS_MAX_BCD  = {4'(HOURS_MAX / 10),  4'(HOURS_MAX % 10)};
  localparam logic [7:0] MINSEC_MAX_BCD = {4'(MINSEC_MAX / 10), 4'(MINSEC_MAX % 10)};

  logic [7:0] seconds_q, seconds_d;
  logic [7:0] minutes_q, minutes_d;
  logic [7:0] hours_q,   hours_d;
  logic       day_wrap_q, day_wrap_d;

  logic       normal_step;
  logic       set_step;
  logic       sec_step;
  logic       min_step;
  logic       hour_step;
  logic       sec_carry;
  logic       min_carry;

  // One BCD increment: wrap to 00 at the field limit, otherwise ripple the
  // ones digit into the tens digit at 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] max_value);
    logic [7:0] result;
    if (value == max_value) begin
      result = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

  // Step and carry decode. Normal mode only listens to the 1 Hz tick and set
  // mode only to the set tick, so the ignored strobe never needs masking
  // anywhere else. Counters_Reset kills the seconds step, which also kills
  // the carry chain for that cycle.
  always_comb begin
    normal_step = i_Tick_1Hz & ~i_Counters_Enable_Increment;
    set_step    = i_Tick_Set &  i_Counters_Enable_Increment;

    sec_carry = normal_step & i_Counters_Enable_Count[0] & ~i_Counters_Reset &
                (seconds_q == MINSEC_MAX_BCD);
    min_carry = sec_carry & i_Counters_Enable_Count[1] &
                (minutes_q == MINSEC_MAX_BCD);

    sec_step  = (normal_step | set_step) & i_Counters_Enable_Count[0] &
                ~i_Counters_Reset;
    min_step  = (set_step & i_Counters_Enable_Count[1]) | min_carry;
    hour_step = (set_step & i_Counters_Enable_Count[2]) |
                (min_carry & i_Counters_Enable_Count[2]);
  end

  // Next-state values for every field plus the day wrap pulse, which only
  // fires when the full normal-mode carry chain reaches the hour limit.
  always_comb begin
    seconds_d  = seconds_q;
    minutes_d  = minutes_q;
    hours_d    = hours_q;
    day_wrap_d = 1'b0;

    if (i_Counters_Reset) begin
      seconds_d = 8'h00;
    end else if (sec_step) begin
      seconds_d = bcd_inc(seconds_q, MINSEC_MAX_BCD);
    end

    if (min_step) begin
      minutes_d = bcd_inc(minutes_q, MINSEC_MAX_BCD);
    end

    if (hour_step) begin
      hours_d = bcd_inc(hours_q, HOURS_MAX_BCD);
    end

    day_wrap_d = min_carry & i_Counters_Enable_Count[2] &
                 (hours_q == HOURS_MAX_BCD);
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      seconds_q  <= 8'h00;
      minutes_q  <= 8'h00;
      hours_q    <= 8'h00;
      day_wrap_q <= 1'b0;
    end else begin
      seconds_q  <= seconds_d;
      minutes_q  <= minutes_d;
      hours_q    <= hours_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign o_Seconds  = seconds_q;
  assign o_Minutes  = minutes_q;
  assign o_Hours    = hours_q;
  assign o_Day_Wrap = day_wrap_q;

endmodule

// File: tb/tb_time_counters.sv
// ---------------------------------------------------------------------------
// tb_time_counters
//
// Directed bench for time_counters. Each driven cycle pushes its hand-written
// expected register state into a scoreboard queue; a separate monitor pops
// one entry after every rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_time_counters;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       tick_set;
  logic       cnt_reset;
  logic       cnt_inc;
  logic [2:0] cnt_en;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       day_wrap;

  typedef struct {
    logic       chk;
    string      name;
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  time_counters #(
    .HOURS_MAX  (23),
    .MINSEC_MAX (59)
  ) dut (
    .i_Clock                     (clk),
    .i_Reset                     (rst),
    .i_Tick_1Hz                  (tick_1hz),
    .i_Tick_Set                  (tick_set),
    .i_Counters_Reset            (cnt_reset),
    .i_Counters_Enable_Increment (cnt_inc),
    .i_Counters_Enable_Count     (cnt_en),
    .o_Seconds                   (seconds),
    .o_Minutes                   (minutes),
    .o_Hours                     (hours),
    .o_Day_Wrap                  (day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one scoreboard entry against the registered outputs.
  task automatic checkOutput(input exp_t e);
    vectors++;
    if (hours !== e.hr || minutes !== e.mn || seconds !== e.sc || day_wrap !== e.wrap) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h:%h:%h wrap=%b, expected %h:%h:%h wrap=%b",
               e.name, hours, minutes, seconds, day_wrap, e.hr, e.mn, e.sc, e.wrap);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(input logic r, input logic t1, input logic ts,
                               input logic cr, input logic inc, input logic [2:0] en,
                               input logic chk, input string name,
                               input logic [7:0] eh, input logic [7:0] em,
                               input logic [7:0] es, input logic ew);
    exp_t e;
    @(negedge clk);
    rst       = r;
    tick_1hz  = t1;
    tick_set  = ts;
    cnt_reset = cr;
    cnt_inc   = inc;
    cnt_en    = en;
    e.chk  = chk;
    e.name = name;
    e.hr   = eh;
    e.mn   = em;
    e.sc   = es;
    e.wrap = ew;
    sb.push_back(e);
  endtask

  function automatic int bcdToInt(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Reset, then step each field in set mode up to the target, then one idle
  // cycle that checks the preloaded value.
  task automatic preload(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, "preload_rst", 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < bcdToInt(s); i++)
      applyStimulus(0, 0, 1, 0, 1, 3'b001, 0, "preload_s", 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < bcdToInt(m); i++)
      applyStimulus(0, 0, 1, 0, 1, 3'b010, 0, "preload_m", 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < bcdToInt(h); i++)
      applyStimulus(0, 0, 1, 0, 1, 3'b100, 0, "preload_h", 8'h00, 8'h00, 8'h00, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 1, "preload_value", h, m, s, 0);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) checkOutput(e);
    end
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; tick_set = 1'b0;
    cnt_reset = 1'b0; cnt_inc = 1'b0; cnt_en = 3'b000;

    // Reset held two cycles with both ticks active.
    applyStimulus(1, 1, 1, 0, 0, 3'b111, 1, "reset_1", 8'h00, 8'h00, 8'h00, 0);
    applyStimulus(1, 1, 1, 0, 1, 3'b111, 1, "reset_2", 8'h00, 8'h00, 8'h00, 0);

    // Normal carry through minutes into hours.
    preload(8'h12, 8'h59, 8'h58);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "carry_59", 8'h12, 8'h59, 8'h59, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "carry_13", 8'h13, 8'h00, 8'h00, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'b111, 1, "no_tick_hold", 8'h13, 8'h00, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "carry_01", 8'h13, 8'h00, 8'h01, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'b111, 1, "set_tick_ignored", 8'h13, 8'h00, 8'h01, 0);

    // Seconds ones-to-tens digit ripple.
    preload(8'h00, 8'h00, 8'h09);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "sec_digit_ripple", 8'h00, 8'h00, 8'h10, 0);

    // Day wrap pulse lasts exactly one cycle.
    preload(8'h23, 8'h59, 8'h59);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "day_wrap_hi", 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 0, 3'b111, 1, "day_wrap_lo", 8'h00, 8'h00, 8'h00, 0);

    // Set minutes: wraps alone, no hour carry, 1 Hz ignored.
    preload(8'h00, 8'h59, 8'h30);
    applyStimulus(0, 0, 1, 0, 1, 3'b010, 1, "set_min_wrap", 8'h00, 8'h00, 8'h30, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'b010, 1, "set_1hz_ignored", 8'h00, 8'h00, 8'h30, 0);
    applyStimulus(0, 0, 1, 0, 1, 3'b010, 1, "set_min_step", 8'h00, 8'h01, 8'h30, 0);

    // Set hours: wrap to 00 without a day wrap pulse.
    preload(8'h23, 8'h10, 8'h00);
    applyStimulus(0, 0, 1, 0, 1, 3'b100, 1, "set_hour_wrap", 8'h00, 8'h10, 8'h00, 0);

    // Set mode with all fields enabled: independent wraps, no carry, no pulse.
    preload(8'h23, 8'h59, 8'h59);
    applyStimulus(0, 0, 1, 0, 1, 3'b111, 1, "set_all_wrap", 8'h00, 8'h00, 8'h00, 0);

    // Seconds reset from the control unit.
    preload(8'h05, 8'h07, 8'h59);
    applyStimulus(0, 1, 0, 1, 0, 3'b000, 1, "cnt_reset_sec", 8'h05, 8'h07, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'b000, 1, "released_disabled", 8'h05, 8'h07, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'b111, 1, "reenabled", 8'h05, 8'h07, 8'h01, 0);

    // Counters_Reset with tick and full enables: no carry into minutes.
    preload(8'h00, 8'h59, 8'h59);
    applyStimulus(0, 1, 0, 1, 0, 3'b111, 1, "cnt_reset_blocks_carry", 8'h00, 8'h59, 8'h00, 0);

    // Disabled minutes hold and block carry to hours.
    preload(8'h00, 8'h59, 8'h59);
    applyStimulus(0, 1, 0, 0, 0, 3'b101, 1, "min_disabled_blocks", 8'h00, 8'h59, 8'h00, 0);

    // Disabled hours hold while minutes wrap; no day wrap.
    preload(8'h23, 8'h59, 8'h59);
    applyStimulus(0, 1, 0, 0, 0, 3'b011, 1, "hour_disabled", 8'h23, 8'h00, 8'h00, 0);

    // Reset mid-operation with a set tick pending.
    preload(8'h12, 8'h34, 8'h56);
    applyStimulus(1, 0, 1, 0, 1, 3'b111, 1, "reset_mid_op", 8'h00, 8'h00, 8'h00, 0);

    applyStimulus(0, 0, 0, 0, 0, 3'b000, 1, "final_idle", 8'h00, 8'h00, 8'h00, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
